mult_fu: RTL and testbench

- Pipelined integer multiply functional unit, directly downstream of the reservation station.
- Consumes one issued MUL/MULH/MULHSU/MULHU per cycle from the RS issue port and produces a tagged result toward CDB arbitration.
- Drives `mul_in_use` back to the RS so it withholds multiply issue while the unit is blocked.
- Tracks branch masks per in-flight op so mispredicts squash it and branch resolution clears mask bits.

---
 rtl/mult_fu.sv | 212 +++++++++++++++++++++
 tb/tb_mult_fu.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_fu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mult_fu                                                         |
// | Purpose  : Pipelined RV32M multiply unit with branch-mask squash and a     |
// |            CDB back-pressure stall; optional perf counters under the       |
// |            macro MULT_PERF_CNT_EN.                                         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+

`ifndef ROB_LEN
`define ROB_LEN 6
`endif
`ifndef BRAT_SIZE
`define BRAT_SIZE 4
`endif
`ifndef BRAT_LEN
`define BRAT_LEN 2
`endif

module mult_fu #(
  parameter int NUM_STAGES = 4,
  parameter int XLEN       = 32,
  parameter int ROB_LEN    = `ROB_LEN,
  parameter int BRAT_SIZE  = `BRAT_SIZE,
  parameter int BRAT_LEN   = `BRAT_LEN
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 valid_in,
  input  logic [1:0]           func_in,
  input  logic [XLEN-1:0]      opa_in,
  input  logic [XLEN-1:0]      opb_in,
  input  logic [ROB_LEN-1:0]   tag_in,
  input  logic [BRAT_SIZE-1:0] brat_mask_in,
  input  logic [BRAT_SIZE-1:0] brat_mis,
  input  logic                 correct_valid,
  input  logic [BRAT_LEN-1:0]  correct_index,
  input  logic                 cdb_grant,
  output logic                 mul_in_use,
  output logic                 valid_out,
  output logic [XLEN-1:0]      result_out,
  output logic [ROB_LEN-1:0]   tag_out,
  output logic [BRAT_SIZE-1:0] brat_mask_out
`ifdef MULT_PERF_CNT_EN
  ,
  output logic [31:0]          perf_issued,
  output logic [31:0]          perf_done,
  output logic [31:0]          perf_squashed,
  output logic [31:0]          perf_stall
`endif
);

  localparam int c_pw    = 2 * XLEN;
  localparam int c_chunk = c_pw / NUM_STAGES;
  localparam int c_last  = NUM_STAGES - 1;
  localparam logic [c_pw-1:0] c_one        = {{(c_pw-1){1'b0}}, 1'b1};
  // A full-width chunk shifts the one out entirely, and 0 - 1 wraps to all ones.
  localparam logic [c_pw-1:0] c_chunk_mask = (c_one << c_chunk) - c_one;
  localparam logic [1:0] c_fn_mul    = 2'b00;
  localparam logic [1:0] c_fn_mulh   = 2'b01;
  localparam logic [1:0] c_fn_mulhsu = 2'b10;

  logic                 r_valid [NUM_STAGES];
  logic [1:0]           r_func  [NUM_STAGES];
  logic [ROB_LEN-1:0]   r_tag   [NUM_STAGES];
  logic [BRAT_SIZE-1:0] r_mask  [NUM_STAGES];
  logic [c_pw-1:0]      r_opa   [NUM_STAGES];
  logic [c_pw-1:0]      r_opb   [NUM_STAGES];
  logic [c_pw-1:0]      r_psum  [NUM_STAGES];

  logic                 w_src_valid [NUM_STAGES];
  logic [1:0]           w_src_func  [NUM_STAGES];
  logic [ROB_LEN-1:0]   w_src_tag   [NUM_STAGES];
  logic [BRAT_SIZE-1:0] w_src_mask  [NUM_STAGES];
  logic [c_pw-1:0]      w_src_opa   [NUM_STAGES];
  logic [c_pw-1:0]      w_src_opb   [NUM_STAGES];
  logic [c_pw-1:0]      w_src_psum  [NUM_STAGES];
  logic [c_pw-1:0]      w_term      [NUM_STAGES];
  logic                 w_cur_valid [NUM_STAGES];
  logic [BRAT_SIZE-1:0] w_cur_mask  [NUM_STAGES];
  logic                 w_kill      [NUM_STAGES];

  logic                 w_stall;
  logic                 w_accept;
  logic                 w_a_signed;
  logic                 w_b_signed;
  logic [c_pw-1:0]      w_opa_ext;
  logic [c_pw-1:0]      w_opb_ext;
  logic [BRAT_SIZE-1:0] w_clr;

  assign w_stall    = r_valid[c_last] & ~cdb_grant;
  assign mul_in_use = w_stall;
  assign w_accept   = valid_in & ~w_stall;

  assign w_a_signed = (func_in == c_fn_mulh) || (func_in == c_fn_mulhsu);
  assign w_b_signed = (func_in == c_fn_mulh);
  assign w_opa_ext  = {{XLEN{w_a_signed & opa_in[XLEN-1]}}, opa_in};
  assign w_opb_ext  = {{XLEN{w_b_signed & opb_in[XLEN-1]}}, opb_in};

  always_comb begin
    w_clr = '0;
    if (correct_valid)
      w_clr[correct_index] = 1'b1;
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign w_src_valid[k] = w_accept;
      assign w_src_func[k]  = func_in;
      assign w_src_tag[k]   = tag_in;
      assign w_src_mask[k]  = brat_mask_in;
      assign w_src_opa[k]   = w_opa_ext;
      assign w_src_opb[k]   = w_opb_ext;
      assign w_src_psum[k]  = '0;
    end else begin : g_body
      assign w_src_valid[k] = r_valid[k-1];
      assign w_src_func[k]  = r_func[k-1];
      assign w_src_tag[k]   = r_tag[k-1];
      assign w_src_mask[k]  = r_mask[k-1];
      assign w_src_opa[k]   = r_opa[k-1];
      assign w_src_opb[k]   = r_opb[k-1];
      assign w_src_psum[k]  = r_psum[k-1];
    end

    // The entry that will occupy this stage after the edge: held copy when
    // stalled, upstream neighbour otherwise. Masks are checked on that entry.
    assign w_cur_valid[k] = w_stall ? r_valid[k] : w_src_valid[k];
    assign w_cur_mask[k]  = w_stall ? r_mask[k]  : w_src_mask[k];
    assign w_kill[k]      = w_cur_valid[k] && (|(w_cur_mask[k] & brat_mis));

    assign w_term[k] = (w_src_opa[k] * ((w_src_opb[k] >> (k * c_chunk)) & c_chunk_mask))
                       << (k * c_chunk);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        r_valid[k] <= 1'b0;
        r_func[k]  <= '0;
        r_tag[k]   <= '0;
        r_mask[k]  <= '0;
        r_opa[k]   <= '0;
        r_opb[k]   <= '0;
        r_psum[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        r_valid[k] <= w_cur_valid[k] && !w_kill[k];
        r_mask[k]  <= w_cur_mask[k] & ~w_clr;
        if (!w_stall) begin
          r_func[k] <= w_src_func[k];
          r_tag[k]  <= w_src_tag[k];
          r_opa[k]  <= w_src_opa[k];
          r_opb[k]  <= w_src_opb[k];
          r_psum[k] <= w_src_psum[k] + w_term[k];
        end
      end
    end
  end

  assign valid_out     = r_valid[c_last];
  assign tag_out       = r_tag[c_last];
  assign brat_mask_out = r_mask[c_last];
  assign result_out    = (r_func[c_last] == c_fn_mul) ? r_psum[c_last][XLEN-1:0]
                                                      : r_psum[c_last][c_pw-1:XLEN];

`ifdef MULT_PERF_CNT_EN
  logic [31:0] r_perf_issued;
  logic [31:0] r_perf_done;
  logic [31:0] r_perf_squashed;
  logic [31:0] r_perf_stall;
  logic [31:0] w_kill_cnt;

  always_comb begin
    w_kill_cnt = '0;
    for (int k = 0; k < NUM_STAGES; k++)
      w_kill_cnt = w_kill_cnt + {31'd0, w_kill[k]};
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_perf_issued   <= '0;
      r_perf_done     <= '0;
      r_perf_squashed <= '0;
      r_perf_stall    <= '0;
    end else begin
      if (w_accept)
        r_perf_issued <= r_perf_issued + 32'd1;
      if (valid_out && cdb_grant)
        r_perf_done <= r_perf_done + 32'd1;
      r_perf_squashed <= r_perf_squashed + w_kill_cnt;
      if (w_stall)
        r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_issued   = r_perf_issued;
  assign perf_done     = r_perf_done;
  assign perf_squashed = r_perf_squashed;
  assign perf_stall    = r_perf_stall;
`endif

`ifndef SYNTHESIS
  // The RS must withhold issue while the unit is blocked; such an op is dropped.
  a_no_issue_when_busy : assert property (@(posedge clock) disable iff (!reset)
    !(valid_in && mul_in_use))
    else $error("mult_fu: valid_in asserted while mul_in_use");
`endif

endmodule

`default_nettype wire

// File: tb/tb_mult_fu.sv
`default_nettype none
// Scoreboard bench for mult_fu: a queue-based model of in-flight ops
// (position, mask, expected result) is checked by a negedge monitor.

module tb_mult_fu;
  localparam int NS = 4;
  localparam int XL = 32;
  localparam int RL = 6;
  localparam int BS = 4;
  localparam int BL = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          valid_in;
  logic [1:0]    func_in;
  logic [XL-1:0] opa_in;
  logic [XL-1:0] opb_in;
  logic [RL-1:0] tag_in;
  logic [BS-1:0] brat_mask_in;
  logic [BS-1:0] brat_mis;
  logic          correct_valid;
  logic [BL-1:0] correct_index;
  logic          cdb_grant;
  logic          mul_in_use;
  logic          valid_out;
  logic [XL-1:0] result_out;
  logic [RL-1:0] tag_out;
  logic [BS-1:0] brat_mask_out;

  always #5 clock = ~clock;

  mult_fu #(
    .NUM_STAGES(NS), .XLEN(XL), .ROB_LEN(RL), .BRAT_SIZE(BS), .BRAT_LEN(BL)
  ) dut (
    .clock(clock), .reset(reset), .valid_in(valid_in), .func_in(func_in),
    .opa_in(opa_in), .opb_in(opb_in), .tag_in(tag_in), .brat_mask_in(brat_mask_in),
    .brat_mis(brat_mis), .correct_valid(correct_valid), .correct_index(correct_index),
    .cdb_grant(cdb_grant), .mul_in_use(mul_in_use), .valid_out(valid_out),
    .result_out(result_out), .tag_out(tag_out), .brat_mask_out(brat_mask_out)
  );

  typedef struct {
    logic [XL-1:0] res;
    logic [RL-1:0] tag;
    logic [BS-1:0] mask;
    int            pos;
  } exp_t;

  exp_t          mq[$];
  int            vectors = 0;
  int            miscompares = 0;
  int            n_granted = 0;
  bit            mon_en = 1'b0;
  logic          m_st;
  logic [BS-1:0] m_clr;
  logic          mon_ev;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // RISC-V multiply semantics from plain 64-bit integer arithmetic.
  function automatic logic [XL-1:0] ref_mul(input logic [1:0] f, input logic [XL-1:0] a,
                                            input logic [XL-1:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (f)
      2'b00:   p = 64'(ua * ub);
      2'b01:   p = 64'(sa * sb);
      2'b10:   p = 64'(sa * ub);
      default: p = 64'(ua * ub);
    endcase
    return (f == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic bit model_stall();
    return (mq.size() > 0) && (mq[0].pos == NS - 1) && !cdb_grant;
  endfunction

  // Reference model: each op advances one position per unstalled edge.
  always @(posedge clock) begin
    if (!reset) begin
      mq.delete();
    end else begin
      m_st  = model_stall();
      m_clr = correct_valid ? (4'b0001 << correct_index) : 4'b0000;
      if (!m_st) begin
        if (mq.size() > 0 && mq[0].pos == NS - 1)
          void'(mq.pop_front());
        foreach (mq[i]) mq[i].pos = mq[i].pos + 1;
      end
      for (int i = mq.size() - 1; i >= 0; i--)
        if ((mq[i].mask & brat_mis) != 0)
          mq.delete(i);
      foreach (mq[i]) mq[i].mask = mq[i].mask & ~m_clr;
      if (valid_in && !m_st && ((brat_mask_in & brat_mis) == 0))
        mq.push_back('{ref_mul(func_in, opa_in, opb_in), tag_in, brat_mask_in & ~m_clr, 0});
    end
  end

  always @(negedge clock) begin
    if (mon_en) begin
      mon_ev = (mq.size() > 0) && (mq[0].pos == NS - 1);
      chk("valid_out", 64'(valid_out), 64'(mon_ev));
      chk("mul_in_use", 64'(mul_in_use), 64'(mon_ev && !cdb_grant));
      if (mon_ev && valid_out) begin
        chk("result_out", 64'(result_out), 64'(mq[0].res));
        chk("tag_out", 64'(tag_out), 64'(mq[0].tag));
        chk("brat_mask_out", 64'(brat_mask_out), 64'(mq[0].mask));
      end
      if (valid_out && cdb_grant)
        n_granted++;
    end
  end

  task automatic next();
    @(posedge clock);
    #1;
    valid_in      = 1'b0;
    brat_mis      = '0;
    correct_valid = 1'b0;
  endtask

  task automatic issue(input logic [1:0] f, input logic [XL-1:0] a, input logic [XL-1:0] b,
                       input logic [RL-1:0] t, input logic [BS-1:0] m);
    valid_in     = 1'b1;
    func_in      = f;
    opa_in       = a;
    opb_in       = b;
    tag_in       = t;
    brat_mask_in = m;
  endtask

  function automatic logic [XL-1:0] rand_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int g0;
    reset = 1'b0; valid_in = 1'b1; func_in = 2'b00; opa_in = 32'd3; opb_in = 32'd4;
    tag_in = 6'd1; brat_mask_in = '0; brat_mis = '0; correct_valid = 1'b0;
    correct_index = '0; cdb_grant = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_valid_out", 64'(valid_out), 64'd0);
    chk("rst_result_out", 64'(result_out), 64'd0);
    chk("rst_tag_out", 64'(tag_out), 64'd0);
    chk("rst_brat_mask_out", 64'(brat_mask_out), 64'd0);
    chk("rst_mul_in_use", 64'(mul_in_use), 64'd0);
    next();
    reset  = 1'b1;
    mon_en = 1'b1;
    repeat (2) next();

    // Single MUL: latency of NS cycles, visible for one cycle.
    issue(2'b00, 32'd7, 32'hFFFF_FFFD, 6'd5, 4'b0000);
    repeat (3) next();
    @(negedge clock);
    chk("mul_lat_early", 64'(valid_out), 64'd0);
    next();
    @(negedge clock);
    chk("mul_lat_valid", 64'(valid_out), 64'd1);
    chk("mul_lat_result", 64'(result_out), 64'hFFFF_FFEB);
    chk("mul_lat_tag", 64'(tag_out), 64'd5);
    next();
    @(negedge clock);
    chk("mul_one_cycle", 64'(valid_out), 64'd0);

    // Back-to-back high-half variants.
    issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd6, 4'b0000); next();
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd7, 4'b0000); next();
    issue(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd8, 4'b0000); next();
    repeat (6) next();

    // Stall: fill with grant low, hold, then drain.
    cdb_grant = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue(2'($urandom_range(0, 3)), rand_opnd(), rand_opnd(), 6'(10 + i), 4'b0000);
      next();
    end
    repeat (3) next();
    cdb_grant = 1'b1;
    repeat (8) next();

    // Squash: only the op on the surviving branch completes.
    g0 = n_granted;
    issue(2'b00, 32'd3, 32'd5, 6'd20, 4'b0001); next();
    issue(2'b00, 32'd4, 32'd6, 6'd21, 4'b0010); next();
    issue(2'b00, 32'd5, 32'd7, 6'd22, 4'b0001); next();
    brat_mis = 4'b0001; next();
    repeat (8) next();
    chk("squash_completions", 64'(n_granted - g0), 64'd1);

    // Resolve in the issue cycle clears the bit, so a later mispredict misses it.
    g0 = n_granted;
    issue(2'b11, 32'd9, 32'd9, 6'd30, 4'b0010);
    correct_valid = 1'b1; correct_index = 2'd1;
    next();
    brat_mis = 4'b0010; next();
    repeat (8) next();
    chk("resolve_completions", 64'(n_granted - g0), 64'd1);

    // Randomized traffic with back-pressure, squashes and resolutions.
    for (int c = 0; c < 600; c++) begin
      cdb_grant = ($urandom_range(0, 9) < 7);
      if (!model_stall() && $urandom_range(0, 9) < 6)
        issue(2'($urandom_range(0, 3)), rand_opnd(), rand_opnd(), 6'($urandom_range(0, 63)),
              4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15)));
      if ($urandom_range(0, 11) == 0)
        brat_mis = 4'b0001 << $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) begin
        correct_valid = 1'b1;
        correct_index = 2'($urandom_range(0, 3));
      end
      next();
    end

    cdb_grant = 1'b1;
    repeat (12) next();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
